loop_sequencer: RTL and testbench

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_sequencer_if.sv | 30 +++
 rtl/loop_sequencer.sv | 127 ++++++++++++
 tb/tb_loop_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_sequencer_if.sv
// Handshake bundle between the loop sequencer and its ADC/PID/DAC peripherals.
// The master side is the sequencer; the slave side drives enables and done pulses.
interface loop_sequencer_if;
    logic        en;
    logic        clr_err;
    logic        adc_done;
    logic        pid_done;
    logic        dac_done;
    logic        adc_start;
    logic        pid_start;
    logic        dac_start;
    logic        busy;
    logic [1:0]  state;
    logic [15:0] sample_cnt;
    logic        overrun;
    logic        timeout_err;
    logic [1:0]  err_stage;

    modport master (
        input  en, clr_err, adc_done, pid_done, dac_done,
        output adc_start, pid_start, dac_start, busy, state,
               sample_cnt, overrun, timeout_err, err_stage
    );

    modport slave (
        output en, clr_err, adc_done, pid_done, dac_done,
        input  adc_start, pid_start, dac_start, busy, state,
               sample_cnt, overrun, timeout_err, err_stage
    );
endinterface

// File: rtl/loop_sequencer.sv
// Periodic ADC -> PID -> DAC control-loop sequencer with per-stage timeout
// and sticky overrun / timeout error reporting.
module loop_sequencer #(
    parameter int unsigned PERIOD  = 64,
    parameter int unsigned TIMEOUT = 48
) (
    input  logic             clk,
    input  logic             rst,
    loop_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADC  = 2'd1,
        S_PID  = 2'd2,
        S_DAC  = 2'd3
    } state_e;

    localparam logic [15:0] PER_LAST = 16'(PERIOD - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] per_q, per_d;
    logic [15:0] stg_q, stg_d;
    logic [15:0] cnt_q, cnt_d;
    logic        adc_start_q, adc_start_d;
    logic        pid_start_q, pid_start_d;
    logic        dac_start_q, dac_start_d;
    logic        overrun_q, overrun_d;
    logic        tmo_q, tmo_d;
    logic [1:0]  err_stage_q, err_stage_d;
    logic        tick;
    logic        stage_to;

    assign tick = bus.en && (per_q == PER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            per_q       <= 16'd0;
            stg_q       <= 16'd0;
            cnt_q       <= 16'd0;
            adc_start_q <= 1'b0;
            pid_start_q <= 1'b0;
            dac_start_q <= 1'b0;
            overrun_q   <= 1'b0;
            tmo_q       <= 1'b0;
            err_stage_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            stg_q       <= stg_d;
            cnt_q       <= cnt_d;
            adc_start_q <= adc_start_d;
            pid_start_q <= pid_start_d;
            dac_start_q <= dac_start_d;
            overrun_q   <= overrun_d;
            tmo_q       <= tmo_d;
            err_stage_q <= err_stage_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adc_start_d = 1'b0;
        pid_start_d = 1'b0;
        dac_start_d = 1'b0;
        stage_to    = 1'b0;
        per_d       = (bus.en && !tick) ? per_q + 16'd1 : 16'd0;

        // A done in the last allowed cycle takes priority over the timeout.
        unique case (state_q)
            S_IDLE: if (tick) begin
                state_d     = S_ADC;
                adc_start_d = 1'b1;
            end
            S_ADC: if (bus.adc_done) begin
                state_d     = S_PID;
                pid_start_d = 1'b1;
            end else if (stg_q == TO_LAST) begin
                state_d  = S_IDLE;
                stage_to = 1'b1;
            end
            S_PID: if (bus.pid_done) begin
                state_d     = S_DAC;
                dac_start_d = 1'b1;
            end else if (stg_q == TO_LAST) begin
                state_d  = S_IDLE;
                stage_to = 1'b1;
            end
            S_DAC: if (bus.dac_done) begin
                state_d = S_IDLE;
            end else if (stg_q == TO_LAST) begin
                state_d  = S_IDLE;
                stage_to = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        stg_d = (state_q == S_IDLE || state_d != state_q) ? 16'd0 : stg_q + 16'd1;
        cnt_d = (state_q == S_DAC && bus.dac_done) ? cnt_q + 16'd1 : cnt_q;

        overrun_d   = overrun_q;
        tmo_d       = tmo_q;
        err_stage_d = err_stage_q;
        if (bus.clr_err) begin
            overrun_d   = 1'b0;
            tmo_d       = 1'b0;
            err_stage_d = 2'd0;
        end
        // Set events are applied after the clear so they win a same-cycle collision.
        if (tick && state_q != S_IDLE) overrun_d = 1'b1;
        if (stage_to) begin
            tmo_d       = 1'b1;
            err_stage_d = state_q;
        end
    end

    assign bus.adc_start   = adc_start_q;
    assign bus.pid_start   = pid_start_q;
    assign bus.dac_start   = dac_start_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.state       = state_q;
    assign bus.sample_cnt  = cnt_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = tmo_q;
    assign bus.err_stage   = err_stage_q;
endmodule

// File: tb/tb_loop_sequencer.sv
// Randomized bench for loop_sequencer: a timing model built from tick times and
// per-stage reply delays predicts starts, end of iteration, counts and error flags.
module tb_loop_sequencer;
    localparam int PER = 64;
    localparam int TMO = 48;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0, n_err = 0;
    int   n_adc = 0, n_pid = 0, n_dac = 0, n_multi = 0;
    int   e_adc = 0, e_pid = 0, e_dac = 0;
    int   e_cnt = 0, e_es = 0;
    bit   e_ovr = 0, e_tmo = 0;
    int   next_tick = 0;

    loop_sequencer_if bus();

    loop_sequencer #(.PERIOD(PER), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        n_adc <= n_adc + int'(bus.adc_start);
        n_pid <= n_pid + int'(bus.pid_start);
        n_dac <= n_dac + int'(bus.dac_start);
        if (int'(bus.adc_start) + int'(bus.pid_start) + int'(bus.dac_start) > 1)
            n_multi <= n_multi + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        bus.adc_done = 1'b0;
        bus.pid_done = 1'b0;
        bus.dac_done = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    // Done pulses for stages other than st; the sequencer must ignore them.
    task automatic stray(input int st);
        if (st != 1 && $urandom_range(3) == 0) bus.adc_done = 1'b1;
        if (st != 2 && $urandom_range(3) == 0) bus.pid_done = 1'b1;
        if (st != 3 && $urandom_range(3) == 0) bus.dac_done = 1'b1;
    endtask

    task automatic set_done(input int st);
        case (st)
            1: bus.adc_done = 1'b1;
            2: bus.pid_done = 1'b1;
            default: bus.dac_done = 1'b1;
        endcase
    endtask

    function automatic logic start_of(input int st);
        case (st)
            1: return bus.adc_start;
            2: return bus.pid_start;
            default: return bus.dac_start;
        endcase
    endfunction

    function automatic int rnd_delay();
        if ($urandom_range(9) == 0) return 47 + int'($urandom_range(3));
        return int'($urandom_range(30));
    endfunction

    task automatic end_checks();
        chk("idle_state", 32'(bus.state), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("sample_cnt", 32'(bus.sample_cnt), e_cnt & 32'hFFFF);
        chk("overrun", 32'(bus.overrun), 32'(e_ovr));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_tmo));
        chk("err_stage", 32'(bus.err_stage), e_es);
    endtask

    // One iteration starting at the predicted tick; a delay >= TMO means withheld.
    task automatic run_iter(input int d1, input int d2, input int d3, input bit drop_en);
        int  s, e, d[3];
        bit  ok;
        s = next_tick;
        while (cyc < s) begin
            step();
            if (cyc < s) stray(0);
        end
        if (drop_en) bus.en = 1'b0;
        d  = '{d1, d2, d3};
        ok = 1'b1;
        e  = s;
        for (int j = 0; j < 3 && ok; j++) begin
            int st = j + 1;
            chk($sformatf("start%0d", st), 32'(start_of(st)), 1);
            chk("stage_state", 32'(bus.state), st);
            chk("stage_busy", 32'(bus.busy), 1);
            if (st == 1) e_adc++;
            else if (st == 2) e_pid++;
            else e_dac++;
            if (d[j] < TMO) begin
                for (int i = 0; i < d[j]; i++) begin
                    step();
                    stray(st);
                end
                set_done(st);
                step();
            end else begin
                for (int i = 0; i < TMO - 1; i++) begin
                    step();
                    stray(st);
                end
                chk("pre_timeout_state", 32'(bus.state), st);
                step();
                ok    = 1'b0;
                e_tmo = 1'b1;
                e_es  = st;
            end
            e = cyc;
        end
        if (ok) e_cnt++;
        if (!drop_en) begin
            // Ticks landing while busy are lost and flag an overrun.
            while (next_tick <= e) begin
                if (next_tick > s) e_ovr = 1'b1;
                next_tick += PER;
            end
        end
        end_checks();
        if ($urandom_range(3) == 0) begin
            bus.clr_err = 1'b1;
            e_ovr = 1'b0;
            e_tmo = 1'b0;
            e_es  = 0;
            step();
            chk("clr_overrun", 32'(bus.overrun), 0);
            chk("clr_timeout", 32'(bus.timeout_err), 0);
            chk("clr_err_stage", 32'(bus.err_stage), 0);
        end
    endtask

    initial begin
        int s;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.clr_err  = 1'b0;
        bus.adc_done = 1'b0;
        bus.pid_done = 1'b0;
        bus.dac_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_starts", {29'd0, bus.adc_start, bus.pid_start, bus.dac_start}, 0);
        chk("rst_cnt", 32'(bus.sample_cnt), 0);
        chk("rst_flags", {29'd0, bus.overrun, bus.timeout_err, 1'b0}, 0);
        chk("rst_err_stage", 32'(bus.err_stage), 0);

        rst       = 1'b0;
        bus.en    = 1'b1;
        next_tick = cyc + PER;

        run_iter(3, 3, 3, 1'b0);
        run_iter(60, 0, 0, 1'b0);
        run_iter(47, 2, 2, 1'b0);
        run_iter(20, 20, 40, 1'b0);
        run_iter(5, 48, 0, 1'b0);
        run_iter(0, 0, 47, 1'b0);
        repeat (20) run_iter(rnd_delay(), rnd_delay(), rnd_delay(), 1'b0);

        // Drop en mid-iteration: iteration completes, then nothing starts.
        run_iter(4, 4, 4, 1'b1);
        repeat (3 * PER) begin
            step();
            stray(0);
        end
        #1;
        chk("no_start_en0", n_adc, e_adc);
        chk("idle_en0", 32'(bus.state), 0);
        bus.en    = 1'b1;
        next_tick = cyc + PER;
        run_iter(3, 3, 3, 1'b0);

        // Reset asserted in the cycle pid_start is high.
        s = next_tick;
        while (cyc < s) step();
        chk("pre_rst_adc_start", 32'(bus.adc_start), 1);
        e_adc++;
        step();
        step();
        bus.adc_done = 1'b1;
        step();
        chk("pre_rst_pid_start", 32'(bus.pid_start), 1);
        chk("pre_rst_state", 32'(bus.state), 2);
        e_pid++;
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_pid_start", 32'(bus.pid_start), 0);
        chk("arst_cnt", 32'(bus.sample_cnt), 0);
        chk("arst_flags", {30'd0, bus.overrun, bus.timeout_err}, 0);
        e_cnt = 0;
        e_ovr = 1'b0;
        e_tmo = 1'b0;
        e_es  = 0;
        step();
        step();
        rst       = 1'b0;
        next_tick = cyc + PER;
        while (cyc < next_tick - 1) step();
        chk("post_rst_no_early", 32'(bus.adc_start), 0);
        run_iter(3, 3, 3, 1'b0);

        step();
        #1;
        chk("n_adc", n_adc, e_adc);
        chk("n_pid", n_pid, e_pid);
        chk("n_dac", n_dac, e_dac);
        chk("start_exclusive", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
